// File: rtl/gate_seq_pkg.sv
// gate_seq_pkg: shared definitions for the AXI4-Stream gate/pulse sequencer.
//   - default field widths and helpers that derive field offsets inside the
//     packed command word {step, level, poff, duration} (LSB first)
//   - sequencer state enum
package gate_seq_pkg;

   localparam int unsigned CNTR_WIDTH_DEF  = 32;
   localparam int unsigned POFF_WIDTH_DEF  = 32;
   localparam int unsigned LEVEL_WIDTH_DEF = 16;

   // Field offsets inside the command word
   function automatic int unsigned poff_lsb(input int unsigned cntr_w);
      return cntr_w;
   endfunction

   function automatic int unsigned level_lsb(input int unsigned cntr_w, input int unsigned poff_w);
      return cntr_w + poff_w;
   endfunction

   function automatic int unsigned step_lsb(input int unsigned cntr_w, input int unsigned poff_w,
                                            input int unsigned level_w);
      return cntr_w + poff_w + level_w;
   endfunction

   function automatic int unsigned cmd_width(input int unsigned cntr_w, input int unsigned poff_w,
                                             input int unsigned level_w);
      return cntr_w + poff_w + 2 * level_w;
   endfunction

   localparam int unsigned DATA_WIDTH_DEF = CNTR_WIDTH_DEF + POFF_WIDTH_DEF + 2 * LEVEL_WIDTH_DEF;

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } state_e;

endpackage

// File: rtl/axis_gate_sequencer_if.sv
// axis_gate_sequencer_if: AXI4-Stream command channel into the sequencer.
//   tdata  : packed command {step, level, poff, duration}, LSB first
//   tvalid : command valid (master -> slave)
//   tready : command accepted when high with tvalid (slave -> master)
interface axis_gate_sequencer_if #(
   parameter int unsigned DATA_WIDTH = gate_seq_pkg::DATA_WIDTH_DEF
);
   logic [DATA_WIDTH-1:0] tdata;
   logic                  tvalid;
   logic                  tready;

   modport master (output tdata, output tvalid, input  tready);
   modport slave  (input  tdata, input  tvalid, output tready);
endinterface

// File: rtl/gate_seq_sat_add.sv
// gate_seq_sat_add: combinational unsigned level plus signed step, clamped to
// [0, 2^LEVEL_WIDTH-1].
//   i_level : current unsigned level
//   i_step  : two's-complement per-cycle step
//   o_level : saturated sum
module gate_seq_sat_add #(
   parameter int unsigned LEVEL_WIDTH = 16
) (
   input  logic [LEVEL_WIDTH-1:0] i_level,
   input  logic [LEVEL_WIDTH-1:0] i_step,
   output logic [LEVEL_WIDTH-1:0] o_level
);

   // Two guard bits: sum spans [-2^(W-1), 2^W + 2^(W-1) - 2], so bit W+1 is the
   // sign and bit W flags overflow above the unsigned maximum.
   logic [LEVEL_WIDTH+1:0] w_sum;

   assign w_sum = {2'b00, i_level} + {{2{i_step[LEVEL_WIDTH-1]}}, i_step};

   always_comb begin
      if (w_sum[LEVEL_WIDTH+1]) begin
         o_level = '0;
      end else if (w_sum[LEVEL_WIDTH]) begin
         o_level = '1;
      end else begin
         o_level = w_sum[LEVEL_WIDTH-1:0];
      end
   end

endmodule

// File: rtl/axis_gate_sequencer.sv
// axis_gate_sequencer: plays AXI4-Stream pulse commands back to back, driving
// phase offset, amplitude level and the RF gate.
//   aclk, aresetn : clock, synchronous active-low reset
//   s_axis        : command stream {step, level, poff, duration}
//   underrun_clr  : clears the sticky underrun flag
//   poff          : phase offset of the current command
//   level         : current amplitude (unsigned)
//   dout          : gate, high while active and level != 0
//   busy          : a command is active
//   underrun      : a command ended with no successor queued
// Build option: GATE_SEQ_RAMP_EN enables the per-cycle saturating level ramp;
// without it the step field is ignored and level is constant per command.
module axis_gate_sequencer
   import gate_seq_pkg::*;
#(
   parameter int unsigned CNTR_WIDTH  = CNTR_WIDTH_DEF,
   parameter int unsigned POFF_WIDTH  = POFF_WIDTH_DEF,
   parameter int unsigned LEVEL_WIDTH = LEVEL_WIDTH_DEF
) (
   input  logic                   aclk,
   input  logic                   aresetn,
   axis_gate_sequencer_if.slave   s_axis,
   input  logic                   underrun_clr,
   output logic [POFF_WIDTH-1:0]  poff,
   output logic [LEVEL_WIDTH-1:0] level,
   output logic                   dout,
   output logic                   busy,
   output logic                   underrun
);

   localparam int unsigned POFF_LSB  = poff_lsb(CNTR_WIDTH);
   localparam int unsigned LEVEL_LSB = level_lsb(CNTR_WIDTH, POFF_WIDTH);
   localparam int unsigned STEP_LSB  = step_lsb(CNTR_WIDTH, POFF_WIDTH, LEVEL_WIDTH);
   localparam int unsigned DATA_W    = cmd_width(CNTR_WIDTH, POFF_WIDTH, LEVEL_WIDTH);

   // Command fields
   logic [CNTR_WIDTH-1:0]  w_cmd_dur;
   logic [POFF_WIDTH-1:0]  w_cmd_poff;
   logic [LEVEL_WIDTH-1:0] w_cmd_level;
   logic [LEVEL_WIDTH-1:0] w_cmd_step;

   assign w_cmd_dur   = s_axis.tdata[POFF_LSB-1:0];
   assign w_cmd_poff  = s_axis.tdata[LEVEL_LSB-1:POFF_LSB];
   assign w_cmd_level = s_axis.tdata[STEP_LSB-1:LEVEL_LSB];
   assign w_cmd_step  = s_axis.tdata[DATA_W-1:STEP_LSB];

   // State and datapath registers
   state_e                 r_state, w_state_nxt;
   logic [CNTR_WIDTH-1:0]  r_cnt, w_cnt_nxt;
   logic [POFF_WIDTH-1:0]  r_poff, w_poff_nxt;
   logic [LEVEL_WIDTH-1:0] r_level, w_level_nxt;
   logic                   r_underrun, w_underrun_nxt;

   logic                   w_tready;
   logic                   w_accept;
   logic                   w_last;
   logic [LEVEL_WIDTH-1:0] w_level_ramp;

   assign w_last   = (r_cnt == CNTR_WIDTH'(1));
   assign w_accept = s_axis.tvalid & w_tready;

`ifdef GATE_SEQ_RAMP_EN
   logic [LEVEL_WIDTH-1:0] r_step;

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         r_step <= '0;
      end else if (w_accept) begin
         r_step <= w_cmd_step;
      end
   end

   gate_seq_sat_add #(
      .LEVEL_WIDTH (LEVEL_WIDTH)
   ) u_sat_add (
      .i_level (r_level),
      .i_step  (r_step),
      .o_level (w_level_ramp)
   );
`else
   // Step field is carried in tdata but deliberately ignored in this build.
   logic w_unused_step;

   assign w_unused_step = ^w_cmd_step;
   assign w_level_ramp  = r_level;
`endif

   // State register
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         r_state    <= IDLE;
         r_cnt      <= '0;
         r_poff     <= '0;
         r_level    <= '0;
         r_underrun <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_poff     <= w_poff_nxt;
         r_level    <= w_level_nxt;
         r_underrun <= w_underrun_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt    = r_state;
      w_cnt_nxt      = r_cnt;
      w_poff_nxt     = r_poff;
      w_level_nxt    = r_level;
      w_underrun_nxt = r_underrun & ~underrun_clr;

      if (w_accept) begin
         // Zero duration still plays for one cycle
         w_state_nxt = ACTIVE;
         w_cnt_nxt   = (w_cmd_dur == '0) ? CNTR_WIDTH'(1) : w_cmd_dur;
         w_poff_nxt  = w_cmd_poff;
         w_level_nxt = w_cmd_level;
      end else if (r_state == ACTIVE) begin
         if (!w_last) begin
            w_cnt_nxt   = r_cnt - CNTR_WIDTH'(1);
            w_level_nxt = w_level_ramp;
         end else begin
            // Last cycle with nothing queued: drop the gate, keep poff.
            // Setting wins over a simultaneous clear.
            w_state_nxt    = IDLE;
            w_cnt_nxt      = '0;
            w_level_nxt    = '0;
            w_underrun_nxt = 1'b1;
         end
      end
   end

   // Outputs
   always_comb begin
      w_tready = aresetn & ((r_state == IDLE) | ((r_state == ACTIVE) & w_last));
      busy     = (r_state == ACTIVE);
      dout     = (r_state == ACTIVE) & (r_level != '0);
      poff     = r_poff;
      level    = r_level;
      underrun = r_underrun;
   end

   assign s_axis.tready = w_tready;

endmodule

// File: tb/tb_axis_gate_sequencer.sv
// tb_axis_gate_sequencer: directed vector table for the command sequencing
// corner cases, then randomized commands checked against a behavioural model.
module tb_axis_gate_sequencer;

   localparam int unsigned CW = 32;
   localparam int unsigned PW = 32;
   localparam int unsigned LW = 16;
   localparam int unsigned DW = CW + PW + 2 * LW;
`ifdef GATE_SEQ_RAMP_EN
   localparam bit RAMP = 1'b1;
`else
   localparam bit RAMP = 1'b0;
`endif

   logic          aclk = 1'b0;
   logic          aresetn = 1'b0;
   logic          underrun_clr = 1'b0;
   logic [PW-1:0] poff;
   logic [LW-1:0] level;
   logic          dout;
   logic          busy;
   logic          underrun;

   axis_gate_sequencer_if #(.DATA_WIDTH(DW)) s_axis ();

   axis_gate_sequencer #(
      .CNTR_WIDTH  (CW),
      .POFF_WIDTH  (PW),
      .LEVEL_WIDTH (LW)
   ) dut (
      .aclk         (aclk),
      .aresetn      (aresetn),
      .s_axis       (s_axis),
      .underrun_clr (underrun_clr),
      .poff         (poff),
      .level        (level),
      .dout         (dout),
      .busy         (busy),
      .underrun     (underrun)
   );

   always #5 aclk = ~aclk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   typedef struct {
      bit          rst_n;
      bit          valid;
      int unsigned dur;
      int unsigned lvl;
      int unsigned step;
      int unsigned cpoff;
      bit          clr;
      bit          e_tready;
      bit          e_busy;
      int unsigned e_level;
      int unsigned e_poff;
      bit          e_ur;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input bit rst_n, input bit valid, input int unsigned dur,
                      input int unsigned lvl, input int unsigned step, input int unsigned cpoff,
                      input bit clr, input bit e_tready, input bit e_busy,
                      input int unsigned e_level, input int unsigned e_poff, input bit e_ur);
      vec_t v;
      v.rst_n = rst_n; v.valid = valid; v.dur = dur; v.lvl = lvl; v.step = step;
      v.cpoff = cpoff; v.clr = clr; v.e_tready = e_tready; v.e_busy = e_busy;
      v.e_level = e_level; v.e_poff = e_poff; v.e_ur = e_ur;
      vecs.push_back(v);
   endtask

   task automatic drive(input bit rst_n, input bit valid, input int unsigned dur,
                        input int unsigned lvl, input int unsigned step, input int unsigned cpoff,
                        input bit clr);
      aresetn       = rst_n;
      s_axis.tvalid = valid;
      s_axis.tdata  = {LW'(step), LW'(lvl), PW'(cpoff), CW'(dur)};
      underrun_clr  = clr;
   endtask

   // Behavioural reference: current command, its remaining cycles and level.
   bit          m_busy;
   longint      m_rem;
   int unsigned m_poff;
   int          m_level;
   int          m_step;
   bit          m_ur;

   function automatic int clamp_level(input int v);
      if (v < 0) return 0;
      if (v > (1 << LW) - 1) return (1 << LW) - 1;
      return v;
   endfunction

   initial begin : watchdog
      #500us;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin : main
      bit          e_tr;
      bit          acc;
      bit          setf;
      bit          r_n, vld, clr;
      int unsigned dur, lvl, cpoff;
      logic [LW-1:0] stp;

      // rst,v,dur,lvl,step,poff,clr | tready,busy,level,poff,underrun
      add(0, 0, 0, 0, 0, 0, 0,               0, 0, 0, 0, 0);
      add(0, 1, 3, 'h100, 0, 'h1234, 0,      0, 0, 0, 0, 0);
      add(1, 1, 3, 'h100, 0, 'h1234, 0,      1, 1, 'h100, 'h1234, 0);
      add(1, 0, 0, 0, 0, 0, 0,               0, 1, 'h100, 'h1234, 0);
      add(1, 0, 0, 0, 0, 0, 0,               0, 1, 'h100, 'h1234, 0);
      add(1, 0, 0, 0, 0, 0, 0,               1, 0, 0, 'h1234, 1);
      add(1, 0, 0, 0, 0, 0, 1,               1, 0, 0, 'h1234, 0);
      // D=2 then D=4 with tvalid held
      add(1, 1, 2, 'h50, 0, 'hA, 0,          1, 1, 'h50, 'hA, 0);
      add(1, 1, 4, 'h77, 0, 'hB, 0,          0, 1, 'h50, 'hA, 0);
      add(1, 1, 4, 'h77, 0, 'hB, 0,          1, 1, 'h77, 'hB, 0);
      add(1, 0, 0, 0, 0, 0, 0,               0, 1, 'h77, 'hB, 0);
      add(1, 0, 0, 0, 0, 0, 0,               0, 1, 'h77, 'hB, 0);
      add(1, 0, 0, 0, 0, 0, 0,               0, 1, 'h77, 'hB, 0);
      add(1, 0, 0, 0, 0, 0, 0,               1, 0, 0, 'hB, 1);
      add(1, 0, 0, 0, 0, 0, 1,               1, 0, 0, 'hB, 0);
      // D=0, level=0
      add(1, 1, 0, 0, 0, 5, 0,               1, 1, 0, 5, 0);
      add(1, 0, 0, 0, 0, 0, 0,               1, 0, 0, 5, 1);
      add(1, 0, 0, 0, 0, 0, 1,               1, 0, 0, 5, 0);
      // Ramps: 0xFFF0 +8 for 4, then 5 -3 for 3 back to back
      add(1, 1, 4, 'hFFF0, 8, 1, 0,          1, 1, 'hFFF0, 1, 0);
      add(1, 0, 0, 0, 0, 0, 0,               0, 1, RAMP ? 'hFFF8 : 'hFFF0, 1, 0);
      add(1, 0, 0, 0, 0, 0, 0,               0, 1, RAMP ? 'hFFFF : 'hFFF0, 1, 0);
      add(1, 0, 0, 0, 0, 0, 0,               0, 1, RAMP ? 'hFFFF : 'hFFF0, 1, 0);
      add(1, 1, 3, 5, 'hFFFD, 2, 0,          1, 1, 5, 2, 0);
      add(1, 0, 0, 0, 0, 0, 0,               0, 1, RAMP ? 2 : 5, 2, 0);
      add(1, 0, 0, 0, 0, 0, 0,               0, 1, RAMP ? 0 : 5, 2, 0);
      // Underrun set and clear in the same cycle: set wins
      add(1, 0, 0, 0, 0, 0, 1,               1, 0, 0, 2, 1);
      add(1, 0, 0, 0, 0, 0, 1,               1, 0, 0, 2, 0);
      // Reset in cycle 2 of a D=10 command
      add(1, 1, 10, 'h300, 0, 7, 0,          1, 1, 'h300, 7, 0);
      add(1, 0, 0, 0, 0, 0, 0,               0, 1, 'h300, 7, 0);
      add(0, 0, 0, 0, 0, 0, 0,               0, 0, 0, 0, 0);
      add(1, 0, 0, 0, 0, 0, 0,               1, 0, 0, 0, 0);

      foreach (vecs[i]) begin
         drive(vecs[i].rst_n, vecs[i].valid, vecs[i].dur, vecs[i].lvl, vecs[i].step,
               vecs[i].cpoff, vecs[i].clr);
         #4;
         check($sformatf("v%0d.tready", i), 64'(s_axis.tready), 64'(vecs[i].e_tready));
         @(posedge aclk);
         #1;
         check($sformatf("v%0d.busy", i), 64'(busy), 64'(vecs[i].e_busy));
         check($sformatf("v%0d.level", i), 64'(level), 64'(vecs[i].e_level));
         check($sformatf("v%0d.dout", i), 64'(dout),
               64'(vecs[i].e_busy && (vecs[i].e_level != 0)));
         check($sformatf("v%0d.poff", i), 64'(poff), 64'(vecs[i].e_poff));
         check($sformatf("v%0d.underrun", i), 64'(underrun), 64'(vecs[i].e_ur));
      end

      // Randomized phase; the first cycle resets DUT and model together.
      for (int n = 0; n < 3000; n++) begin
         r_n   = (n == 0) ? 1'b0 : ($urandom_range(99) != 0);
         vld   = ($urandom_range(9) < 6);
         dur   = ($urandom_range(9) == 0) ? $urandom_range(20) : $urandom_range(5);
         case ($urandom_range(3))
            0:       lvl = 0;
            1:       lvl = 'hFFFF - $urandom_range(40);
            2:       lvl = $urandom_range(40);
            default: lvl = $urandom_range('hFFFF);
         endcase
         stp   = ($urandom_range(7) == 0) ? LW'($urandom) : LW'($urandom_range(24) - 12);
         cpoff = $urandom;
         clr   = ($urandom_range(9) == 0);

         e_tr = r_n && (!m_busy || m_rem == 1);
         drive(r_n, vld, dur, lvl, int'(stp), cpoff, clr);
         #4;
         check($sformatf("r%0d.tready", n), 64'(s_axis.tready), 64'(e_tr));

         if (!r_n) begin
            m_busy = 0; m_rem = 0; m_poff = 0; m_level = 0; m_step = 0; m_ur = 0;
         end else begin
            acc  = vld && e_tr;
            setf = 0;
            if (acc) begin
               m_busy  = 1;
               m_rem   = (dur == 0) ? 1 : dur;
               m_poff  = cpoff;
               m_level = int'(lvl);
               m_step  = int'($signed(stp));
            end else if (m_busy) begin
               if (m_rem > 1) begin
                  m_rem--;
                  if (RAMP) m_level = clamp_level(m_level + m_step);
               end else begin
                  m_busy  = 0;
                  m_level = 0;
                  setf    = 1;
               end
            end
            if (setf) m_ur = 1;
            else if (clr) m_ur = 0;
         end

         @(posedge aclk);
         #1;
         check($sformatf("r%0d.busy", n), 64'(busy), 64'(m_busy));
         check($sformatf("r%0d.level", n), 64'(level), 64'(m_level));
         check($sformatf("r%0d.dout", n), 64'(dout), 64'(m_busy && m_level != 0));
         check($sformatf("r%0d.poff", n), 64'(poff), 64'(m_poff));
         check($sformatf("r%0d.underrun", n), 64'(underrun), 64'(m_ur));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
